// File: rtl/harvard_mem_pkg.sv
// Shared types and helpers for the split instruction/data memory.
package harvard_mem_pkg;

    typedef enum logic {CLEAR, RUN} state_e;

    // Widest word the byte-merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MaxDw = 1024;
    localparam int unsigned MaxBe = MaxDw / 8;

    function automatic logic [MaxDw-1:0] byte_merge(input logic [MaxDw-1:0] old_word,
                                                    input logic [MaxDw-1:0] new_word,
                                                    input logic [MaxBe-1:0] be);
        logic [MaxDw-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(MaxBe); k++) begin
            if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/harvard_mem_bank.sv
// One memory bank: registered read-first read port and a byte-enable write port.
module mem_bank
    import harvard_mem_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata
);

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= DW'(byte_merge(MaxDw'(mem[waddr]), MaxDw'(wdata), MaxBe'(be)));
        end
    end

    // Out-of-range reads return zero; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ({1'b0, raddr} < DepthW) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/harvard_mem.sv
// Split instruction/data memory with program-load port and post-reset clear sequencer.
module harvard_mem
    import harvard_mem_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_done,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_rvalid,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_rvalid,
    output logic            d_err,
    input  logic            p_we,
    input  logic [AW-1:0]   p_addr,
    input  logic [DW-1:0]   p_wdata
);

    localparam logic [AW:0]   DepthW   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            run, clearing;
    logic            i_oor, d_oor, p_oor;
    logic            i_re, d_re;
    logic            i_wen, d_wen;
    logic [AW-1:0]   i_waddr, d_waddr;
    logic [DW-1:0]   i_wdata, d_wdata_m;
    logic [DW/8-1:0] d_be_m;

    assign run       = (state_q == RUN);
    assign init_done = run;
    assign clearing  = (state_q == CLEAR) && !rst;

    assign i_oor = {1'b0, i_addr} >= DepthW;
    assign d_oor = {1'b0, d_addr} >= DepthW;
    assign p_oor = {1'b0, p_addr} >= DepthW;

    assign i_re = run && i_req;
    assign d_re = run && d_req && !d_we;

    // Clear sequencer owns both write ports until the banks are zeroed.
    always_comb begin
        i_wen     = clearing || (run && !rst && p_we && !p_oor);
        i_waddr   = clearing ? clr_cnt_q : p_addr;
        i_wdata   = clearing ? '0 : p_wdata;
        d_wen     = clearing || (run && !rst && d_req && d_we && !d_oor);
        d_waddr   = clearing ? clr_cnt_q : d_addr;
        d_wdata_m = clearing ? '0 : d_wdata;
        d_be_m    = clearing ? '1 : d_be;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            i_rvalid  <= 1'b0;
            i_err     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            i_rvalid <= i_re;
            i_err    <= i_re && i_oor;
            d_rvalid <= d_re;
            d_err    <= run && d_req && d_oor;
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + AW'(1);
                if (clr_cnt_q == LastAddr) state_q <= RUN;
            end
        end
    end

    mem_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ibank (
        .clk   (clk),
        .rst   (rst),
        .re    (i_re),
        .raddr (i_addr),
        .rdata (i_rdata),
        .we    (i_wen),
        .be    ({(DW/8){1'b1}}),
        .waddr (i_waddr),
        .wdata (i_wdata)
    );

    mem_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_dbank (
        .clk   (clk),
        .rst   (rst),
        .re    (d_re),
        .raddr (d_addr),
        .rdata (d_rdata),
        .we    (d_wen),
        .be    (d_be_m),
        .waddr (d_waddr),
        .wdata (d_wdata_m)
    );

endmodule

// File: tb/tb_harvard_mem.sv
// Directed plus random stimulus for harvard_mem, checked against an array-based model.
module tb_harvard_mem;

    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_rvalid, i_err;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          d_rvalid, d_err;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;

    always #5 clk = ~clk;

    harvard_mem #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_err     (d_err),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata)
    );

    // Reference model: contents and expected outputs after the next edge.
    logic [DW-1:0] imem [DEPTH];
    logic [DW-1:0] dmem [DEPTH];
    int            since_rst = 0;
    logic [DW-1:0] ei_rdata = '0, ed_rdata = '0;
    logic          ei_valid, ei_err, ed_valid, ed_err;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_we = 0; d_be = '0; p_we = 0;
    endtask

    task automatic cyc();
        logic          acc;
        logic [DW-1:0] w;
        acc = !rst && since_rst >= DEPTH;
        if (rst) begin
            ei_valid = 0; ei_err = 0; ed_valid = 0; ed_err = 0;
            ei_rdata = '0; ed_rdata = '0; since_rst = 0;
            for (int i = 0; i < DEPTH; i++) begin imem[i] = '0; dmem[i] = '0; end
        end else begin
            ei_valid = acc && i_req;
            ei_err   = ei_valid && (int'(i_addr) >= DEPTH);
            if (ei_valid) ei_rdata = ei_err ? '0 : imem[i_addr];
            ed_valid = acc && d_req && !d_we;
            ed_err   = acc && d_req && (int'(d_addr) >= DEPTH);
            if (ed_valid) ed_rdata = (int'(d_addr) >= DEPTH) ? '0 : dmem[d_addr];
            if (acc && d_req && d_we && int'(d_addr) < DEPTH) begin
                w = dmem[d_addr];
                for (int k = 0; k < 4; k++) if (d_be[k]) w[8*k +: 8] = d_wdata[8*k +: 8];
                dmem[d_addr] = w;
            end
            if (acc && p_we && int'(p_addr) < DEPTH) imem[p_addr] = p_wdata;
            since_rst++;
        end
        @(posedge clk);
        #1;
        chk("init_done", DW'(init_done), DW'(since_rst >= DEPTH));
        chk("i_rvalid", DW'(i_rvalid), DW'(ei_valid));
        chk("i_err", DW'(i_err), DW'(ei_err));
        chk("i_rdata", i_rdata, ei_rdata);
        chk("d_rvalid", DW'(d_rvalid), DW'(ed_valid));
        chk("d_err", DW'(d_err), DW'(ed_err));
        chk("d_rdata", d_rdata, ed_rdata);
    endtask

    initial begin
        rst = 1; idle();
        i_addr = '0; d_addr = '0; d_wdata = '0; p_addr = '0; p_wdata = '0;
        cyc(); cyc();

        // Clear phase: requests and program loads must be ignored.
        rst = 0;
        i_req = 1; i_addr = 0; d_req = 1; d_addr = 1; p_we = 1; p_addr = 2;
        p_wdata = 32'h1234_5678;
        for (int k = 1; k <= DEPTH; k++) begin
            cyc();
            chk("clear_no_ivalid", DW'(i_rvalid), '0);
        end
        p_we = 0;
        cyc();
        chk("first_accept", DW'(i_rvalid), 32'd1);

        // Every address, including out-of-range ones, reads zero.
        for (int a = 0; a < 16; a++) begin
            i_req = 1; i_addr = AW'(a); d_req = 1; d_we = 0; d_addr = AW'(a);
            cyc();
        end
        idle();

        // Byte-enable merge.
        d_req = 1; d_we = 1; d_addr = 3; d_be = 4'b1111; d_wdata = 32'hAABB_CCDD; cyc();
        d_be = 4'b0101; d_wdata = 32'h1122_3344; cyc();
        d_we = 0; d_be = '0; cyc();
        chk("be_merge", d_rdata, 32'hAA22_CC44);
        idle();

        // Instruction bank read-first collision, then data write/read back-to-back.
        p_we = 1; p_addr = 5; p_wdata = 32'hDEAD_BEEF; i_req = 1; i_addr = 5; cyc();
        chk("collide_old", i_rdata, '0);
        p_we = 0; cyc();
        chk("collide_new", i_rdata, 32'hDEAD_BEEF);
        idle();
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 5; d_wdata = 32'hDEAD_BEEF; cyc();
        d_we = 0; cyc();
        chk("dwrite_visible", d_rdata, 32'hDEAD_BEEF);
        idle();

        // Out-of-range writes are dropped.
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 13; d_wdata = 32'hFFFF_FFFF;
        p_we = 1; p_addr = 13; p_wdata = 32'hFFFF_FFFF; cyc();
        chk("oor_write_err", DW'(d_err), 32'd1);
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            i_req = 1; i_addr = AW'(a); d_req = 1; d_we = 0; d_addr = AW'(a); cyc();
        end
        idle();

        // Reset mid-run wipes a loaded program and reruns the clear.
        p_we = 1; p_addr = 7; p_wdata = 32'hCAFE_F00D; cyc();
        p_we = 0; i_req = 1; i_addr = 7; cyc(); cyc();
        chk("loaded_word", i_rdata, 32'hCAFE_F00D);
        rst = 1; cyc();
        chk("rst_kills_valid", DW'(i_rvalid), '0);
        rst = 0;
        for (int k = 0; k < DEPTH + 2; k++) cyc();
        chk("wiped_word", i_rdata, '0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 149) == 0);
            i_req   = 1'($urandom);
            i_addr  = AW'($urandom_range(0, 15));
            d_req   = 1'($urandom);
            d_we    = 1'($urandom);
            d_be    = 4'($urandom);
            d_addr  = AW'($urandom_range(0, 15));
            d_wdata = $urandom;
            p_we    = 1'($urandom);
            p_addr  = AW'($urandom_range(0, 15));
            p_wdata = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
